// File: rtl/sixteen_bit_accumulator_ctrl.sv
// Accumulating control stage around an external combinational 16-bit adder.
// Collects a frame of operands over valid/ready and presents total, carry and count.
module sixteen_bit_accumulator_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    input  logic [WIDTH-1:0] adder_sum,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic [CNT_W-1:0] out_count,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_r;
    logic [WIDTH-1:0] acc_r;
    logic [CNT_W-1:0] count_r;
    logic             carry_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_sum_r;
    logic             out_carry_r;
    logic [CNT_W-1:0] out_count_r;

    logic             acc_en_s;
    logic             cout_s;
    logic             carry_next_s;
    logic [CNT_W-1:0] count_next_s;

    assign acc_en_s = in_valid & in_ready_r;
    assign adder_b  = in_data;

    // Adder operand A: the running total, forced to zero while no operand is held.
    always_comb begin
        adder_a = {WIDTH{1'b0}};
        if (state_r == ST_IDLE) begin
            adder_a = {WIDTH{1'b0}};
        end else begin
            adder_a = acc_r;
        end
    end

    // Carry out of the MSB reconstructed from operand and sum sign bits.
    always_comb begin
        cout_s       = (adder_a[WIDTH-1] & in_data[WIDTH-1])
                     | ((adder_a[WIDTH-1] ^ in_data[WIDTH-1]) & ~adder_sum[WIDTH-1]);
        carry_next_s = carry_r | cout_s;
        if (count_r == CNT_MAX) begin
            count_next_s = count_r;
        end else begin
            count_next_s = count_r + CNT_ONE;
        end
    end

    // Frame FSM with running state and registered output handshake fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            acc_r       <= {WIDTH{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            carry_r     <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_sum_r   <= {WIDTH{1'b0}};
            out_carry_r <= 1'b0;
            out_count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_ACCUM: begin
                    if (acc_en_s) begin
                        acc_r   <= adder_sum;
                        count_r <= count_next_s;
                        carry_r <= carry_next_s;
                        if (in_last) begin
                            state_r     <= ST_DONE;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            out_sum_r   <= adder_sum;
                            out_carry_r <= carry_next_s;
                            out_count_r <= count_next_s;
                        end else begin
                            state_r <= ST_ACCUM;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        acc_r       <= {WIDTH{1'b0}};
                        count_r     <= {CNT_W{1'b0}};
                        carry_r     <= 1'b0;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                        out_sum_r   <= {WIDTH{1'b0}};
                        out_carry_r <= 1'b0;
                        out_count_r <= {CNT_W{1'b0}};
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    acc_r       <= {WIDTH{1'b0}};
                    count_r     <= {CNT_W{1'b0}};
                    carry_r     <= 1'b0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    out_sum_r   <= {WIDTH{1'b0}};
                    out_carry_r <= 1'b0;
                    out_count_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
    assign out_carry = out_carry_r;
    assign out_count = out_count_r;

endmodule

// File: tb/tb_sixteen_bit_accumulator_ctrl.sv
// Directed bench for sixteen_bit_accumulator_ctrl with a behavioural adder model.
module tb_sixteen_bit_accumulator_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] adder_a;
    logic [15:0] adder_b;
    logic [15:0] adder_sum;
    logic [15:0] out_sum;
    logic        out_carry;
    logic [7:0]  out_count;
    logic        out_valid;
    logic        out_ready;

    int passed = 0;
    int total  = 0;

    sixteen_bit_accumulator_ctrl #(.WIDTH(16), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .adder_a   (adder_a),
        .adder_b   (adder_b),
        .adder_sum (adder_sum),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign adder_sum = adder_a + adder_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present one operand and wait for its accept edge; returns 1 time unit after it.
    task automatic send(input logic [15:0] data, input logic last);
        int waited;
        waited   = 0;
        in_data  = data;
        in_valid = 1'b1;
        in_last  = last;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) chk("send_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic [15:0] s, input logic c, input logic [7:0] n);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"},   32'(out_sum),   32'(s));
        chk({tag, "_carry"}, 32'(out_carry), 32'(c));
        chk({tag, "_count"}, 32'(out_count), 32'(n));
        chk({tag, "_ready"}, 32'(in_ready),  32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = 16'hABCD;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset values
        #12;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum",   32'(out_sum),   32'd0);
        chk("rst_out_carry", 32'(out_carry), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_adder_a",   32'(adder_a),   32'd0);
        chk("rst_adder_b",   32'(adder_b),   32'hABCD);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Three-operand frame
        send(16'h0001, 1'b0);
        chk("f1_adder_a_acc", 32'(adder_a),   32'h0001);
        chk("f1_mid_valid",   32'(out_valid), 32'd0);
        send(16'h0002, 1'b0);
        chk("f1_mid2_valid",  32'(out_valid), 32'd0);
        send(16'h0003, 1'b1);
        chk_result("f1", 16'h0006, 1'b0, 8'd3);
        release_out();
        chk("f1_rel_valid", 32'(out_valid), 32'd0);
        chk("f1_rel_ready", 32'(in_ready),  32'd1);
        chk("f1_rel_sum",   32'(out_sum),   32'd0);
        chk("f1_rel_a",     32'(adder_a),   32'd0);

        // Wrap with carry, then back-pressure with ignored input activity
        send(16'hFFFF, 1'b0);
        send(16'h0002, 1'b1);
        chk_result("wrap", 16'h0001, 1'b1, 8'd2);
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = 16'h7777;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk_result("bp", 16'h0001, 1'b1, 8'd2);
        end
        chk("bp_adder_b", 32'(adder_b), 32'h7777);
        in_valid = 1'b0;
        in_last  = 1'b0;
        release_out();
        chk("bp_rel_ready", 32'(in_ready), 32'd1);

        // Single-operand frame straight after
        send(16'h8000, 1'b1);
        chk_result("single", 16'h8000, 1'b0, 8'd1);
        release_out();

        // Count saturation
        for (int i = 0; i < 300; i++) begin
            send(16'h0001, (i == 299));
        end
        chk_result("sat", 16'h012C, 1'b0, 8'd255);
        release_out();

        // Reset mid-frame
        send(16'h1234, 1'b0);
        send(16'h1111, 1'b0);
        chk("mid_adder_a", 32'(adder_a), 32'h2345);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_ready", 32'(in_ready),  32'd1);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_a",     32'(adder_a),   32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(16'h0005, 1'b1);
        chk_result("after_rst", 16'h0005, 1'b0, 8'd1);
        release_out();
        chk("end_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
